du_im_loader: RTL



---
 rtl/du_im_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/du_im_loader.sv
// Debug-unit instruction loader: waits for WRITE_IM, packs big-endian UART bytes
// into words and writes them to IM from address 0 until HALT or memory full.
module du_im_loader #(
    parameter int unsigned          NB_DATA      = 8,
    parameter int unsigned          NB_INST      = 32,
    parameter int unsigned          NB_ADDR      = 6,
    parameter logic [NB_DATA-1:0]   CMD_WRITE_IM = 8'd1,
    parameter logic [NB_INST-1:0]   HALT_WORD    = 32'hFFFFFFFF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done_tick,
    output logic                 o_im_wr_en,
    output logic [NB_ADDR-1:0]   o_im_addr,
    output logic [NB_INST-1:0]   o_im_data,
    output logic                 o_busy,
    output logic                 o_load_done,
    output logic [NB_ADDR:0]     o_inst_count,
    output logic [2:0]           o_state
);

    localparam int unsigned NB_SHIFT = NB_INST - NB_DATA;
    localparam int unsigned NB_CNT   = NB_ADDR + 1;
    localparam logic [NB_ADDR-1:0] ADDR_MAX = '1;

    // One-hot encoding doubles as the registered o_state output.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RECV = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t              state;
    logic [1:0]          byte_idx;
    logic [NB_SHIFT-1:0] shreg;
    logic                last_word;
    logic [NB_INST-1:0]  word_next;

    // Word as it would look with the current byte appended (first byte ends up MSB).
    always_comb begin
        word_next = {shreg, i_rx_data};
    end

    assign o_state = state;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            byte_idx     <= 2'd0;
            shreg        <= '0;
            last_word    <= 1'b0;
            o_im_wr_en   <= 1'b0;
            o_im_addr    <= '0;
            o_im_data    <= '0;
            o_busy       <= 1'b0;
            o_load_done  <= 1'b0;
            o_inst_count <= '0;
        end else begin
            o_im_wr_en  <= 1'b0;
            o_load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_done_tick && (i_rx_data == CMD_WRITE_IM)) begin
                        state        <= RECV;
                        o_im_addr    <= '0;
                        o_inst_count <= '0;
                        byte_idx     <= 2'd0;
                        shreg        <= '0;
                        last_word    <= 1'b0;
                        o_busy       <= 1'b1;
                    end
                end
                RECV: begin
                    if (o_im_wr_en && last_word) begin
                        // Final word has been written; address stays on it.
                        state       <= DONE;
                        o_load_done <= 1'b1;
                        o_busy      <= 1'b0;
                    end else begin
                        if (o_im_wr_en) begin
                            o_im_addr <= o_im_addr + NB_ADDR'(1);
                        end
                        if (i_rx_done_tick) begin
                            shreg <= word_next[NB_SHIFT-1:0];
                            if (byte_idx == 2'd3) begin
                                o_im_data    <= word_next;
                                o_im_wr_en   <= 1'b1;
                                o_inst_count <= o_inst_count + NB_CNT'(1);
                                byte_idx     <= 2'd0;
                                last_word    <= (word_next == HALT_WORD) || (o_im_addr == ADDR_MAX);
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    last_word <= 1'b0;
                    byte_idx  <= 2'd0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
